// File: rtl/ram_responder.sv
// Memory-side responder: synchronous byte RAM with one-cycle read latency plus
// a memory-mapped output port feeding a byte FIFO drained by a valid/ready consumer.
module ram_responder #(
  parameter int unsigned ADDR_WIDTH = 17,
  parameter logic [31:0] IO_ADDR    = 32'h0003_0000,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_full,
  output logic        io_overflow,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned PW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = PW + 1;

  logic [7:0]            ram [RAM_DEPTH];
  logic [7:0]            fifo [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;

  logic                  io_hit;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [PW-1:0]         rd_nxt;
  logic [PW-1:0]         wr_nxt;
  logic [CW-1:0]         count_nxt;
  logic [7:0]            head_nxt;

  // Decode and FIFO next-state
  always_comb begin
    io_hit    = (mem_addr == IO_ADDR);
    ram_idx   = mem_addr[ADDR_WIDTH-1:0];
    pop       = tx_valid && tx_ready;
    push      = mem_wr && io_hit && (!io_full || pop);
    drop      = mem_wr && io_hit && io_full && !pop;
    rd_nxt    = pop  ? rd_ptr + PW'(1) : rd_ptr;
    wr_nxt    = push ? wr_ptr + PW'(1) : wr_ptr;
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = count - CW'(1);
    end
    // A push landing in the slot that becomes the head has no storage yet to read from
    head_nxt = fifo[rd_nxt];
    if (push && (rd_nxt == wr_ptr)) begin
      head_nxt = mem_dout;
    end
  end

  // RAM array, contents survive reset
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_hit) begin
      ram[ram_idx] <= mem_dout;
    end
  end

  // Read data, FIFO storage, pointers and flags
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      mem_din     <= 8'h00;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      io_full     <= 1'b0;
      io_overflow <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo[i] <= 8'h00;
      end
    end else begin
      if (!mem_wr) begin
        mem_din <= io_hit ? 8'(count) : ram[ram_idx];
      end
      if (push) begin
        fifo[wr_ptr] <= mem_dout;
      end
      if (drop) begin
        io_overflow <= 1'b1;
      end
      rd_ptr   <= rd_nxt;
      wr_ptr   <= wr_nxt;
      count    <= count_nxt;
      io_full  <= (count_nxt == CW'(FIFO_DEPTH));
      tx_valid <= (count_nxt != '0);
      tx_data  <= head_nxt;
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: vector table for RAM/FIFO traffic plus
// hand sequences for push-while-full-and-popping and mid-operation reset.
module tb_ram_responder;

  localparam logic [31:0] IO = 32'h0003_0000;

  logic        clk_in;
  logic        rst_n;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_full;
  logic        io_overflow;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        rdy;
    logic        chk_din;
    logic [7:0]  din;
    logic        valid;
    logic        full;
    logic        ovf;
    logic        chk_data;
    logic [7:0]  data;
  } vec_t;

  vec_t vecs[$];

  ram_responder #(
    .ADDR_WIDTH(17),
    .IO_ADDR   (IO),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_dout   (mem_dout),
    .mem_wr     (mem_wr),
    .mem_din    (mem_din),
    .io_full    (io_full),
    .io_overflow(io_overflow),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] dout, input logic rdy);
    mem_wr   = wr;
    mem_addr = addr;
    mem_dout = dout;
    tx_ready = rdy;
  endtask

  // One cycle: inputs already set, clock, then sample 1ns after the edge
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 8'h00, 1'b0);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [7:0] dout, input logic rdy,
                     input logic chk_din, input logic [7:0] din, input logic valid, input logic full,
                     input logic ovf, input logic chk_data, input logic [7:0] data);
    vec_t v;
    v.wr = wr; v.addr = addr; v.dout = dout; v.rdy = rdy;
    v.chk_din = chk_din; v.din = din; v.valid = valid; v.full = full;
    v.ovf = ovf; v.chk_data = chk_data; v.data = data;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp_seq[$];

    // RAM write/read, aliasing, FIFO fill, overflow and drain
    add(1, 32'h0000_0010, 8'hA5, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);
    add(0, 32'h0000_0010, 8'h00, 0, 1, 8'hA5, 0, 0, 0, 0, 8'h00);
    add(1, 32'h0002_0005, 8'h11, 0, 1, 8'hA5, 0, 0, 0, 0, 8'h00);
    add(0, 32'h0000_0005, 8'h00, 0, 1, 8'h11, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 8; k++)
      add(1, IO, 8'(k), 0, 1, 8'h11, 1, (k == 8), 0, 1, 8'h01);
    add(0, IO, 8'h00, 0, 1, 8'h08, 1, 1, 0, 1, 8'h01);
    add(1, IO, 8'h99, 0, 1, 8'h08, 1, 1, 1, 1, 8'h01);
    for (int i = 0; i < 8; i++)
      add(0, IO, 8'h00, 1, 1, 8'(8 - i), (i < 7), 0, 1, (i < 7), 8'(i + 2));
    add(0, IO, 8'h00, 1, 1, 8'h00, 0, 0, 1, 0, 8'h00);

    do_reset();
    check("reset_din", 32'(mem_din), 32'h0);
    check("reset_valid", 32'(tx_valid), 32'h0);
    check("reset_full", 32'(io_full), 32'h0);
    check("reset_ovf", 32'(io_overflow), 32'h0);
    check("reset_data", 32'(tx_data), 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].dout, vecs[i].rdy);
      step();
      if (vecs[i].chk_din) check($sformatf("v%0d_din", i), 32'(mem_din), 32'(vecs[i].din));
      check($sformatf("v%0d_valid", i), 32'(tx_valid), 32'(vecs[i].valid));
      check($sformatf("v%0d_full", i), 32'(io_full), 32'(vecs[i].full));
      check($sformatf("v%0d_ovf", i), 32'(io_overflow), 32'(vecs[i].ovf));
      if (vecs[i].chk_data) check($sformatf("v%0d_data", i), 32'(tx_data), 32'(vecs[i].data));
    end

    // Full FIFO, consumer ready, write accepted in the same cycle as a pop
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, IO, 8'(8'h10 + k), 0);
      step();
    end
    check("fill_full", 32'(io_full), 32'h1);
    drive(1, IO, 8'h55, 1);
    step();
    check("pp_full", 32'(io_full), 32'h1);
    check("pp_ovf", 32'(io_overflow), 32'h0);
    check("pp_head", 32'(tx_data), 32'h11);
    drive(0, IO, 8'h00, 1);
    got.delete();
    for (int c = 0; c < 20 && (tx_valid || c == 0); c++) begin
      if (c == 1) check("pp_count", 32'(mem_din), 32'h8);
      if (tx_valid) got.push_back(tx_data);
      step();
    end
    exp_seq = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
    check("pp_len", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("pp_seq%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_seq[i]));
    check("pp_empty", 32'(tx_valid), 32'h0);
    check("pp_ovf_end", 32'(io_overflow), 32'h0);

    // Asynchronous reset mid-operation
    drive(1, 32'h0000_0100, 8'h3C, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1, IO, 8'(8'hE0 + k), 0);
      step();
    end
    drive(0, 32'h0000_0100, 8'h00, 0);
    step();
    check("pre_rst_din", 32'(mem_din), 32'h3C);
    check("pre_rst_valid", 32'(tx_valid), 32'h1);
    #1 rst_n = 1'b0;
    #2;
    check("async_valid", 32'(tx_valid), 32'h0);
    check("async_din", 32'(mem_din), 32'h0);
    check("async_full", 32'(io_full), 32'h0);
    #1 rst_n = 1'b1;
    drive(0, IO, 8'h00, 0);
    step();
    check("post_rst_count", 32'(mem_din), 32'h0);
    check("post_rst_valid", 32'(tx_valid), 32'h0);
    drive(0, 32'h0000_0100, 8'h00, 0);
    step();
    check("ram_kept", 32'(mem_din), 32'h3C);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
